// File: rtl/sdrc_tg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdrc_tg_pkg : shared types and data-pattern function for the SDRAM        |
// |               Wishbone traffic generator                                  |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
package sdrc_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_WR_BURST  = 3'd2,
        ST_WR_GAP    = 3'd3,
        ST_RD_BURST  = 3'd4,
        ST_RD_GAP    = 3'd5,
        ST_DONE      = 3'd6
    } tg_state_e;

    typedef enum logic [1:0] {
        TG_WR   = 2'b00,
        TG_RD   = 2'b01,
        TG_WRRD = 2'b10
    } tg_mode_e;

    // Data written to (and expected back from) a given word index.
    function automatic logic [31:0] tg_pattern(input logic [31:0] word_idx,
                                               input logic [31:0] seed);
        return word_idx ^ seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdrc_tg_agen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdrc_tg_agen : address, beat and burst counters for the traffic generator |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sdrc_tg_agen #(
    parameter int AW   = 26,
    parameter int BLW  = 5,
    parameter int STEP = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load,
    input  logic           step,
    input  logic [AW-1:0]  base,
    input  logic [BLW-1:0] burst_len_i,
    input  logic [15:0]    num_bursts_i,
    output logic [AW-1:0]  addr,
    output logic [AW-1:0]  addr_nxt_o,
    output logic           last_beat,
    output logic           last_burst
);

    logic [AW-1:0]  addr_q,  addr_d;
    logic [BLW-1:0] beat_q,  beat_d;
    logic [15:0]    burst_q, burst_d;
    logic [BLW-1:0] w_last_idx;

    assign w_last_idx = (burst_len_i == '0) ? '0 : burst_len_i - BLW'(1);
    assign last_beat  = (beat_q == w_last_idx);
    // burst_q counts completed bursts, so this flags "phase fully issued".
    assign last_burst = (burst_q == num_bursts_i);
    assign addr       = addr_q;
    assign addr_nxt_o = addr_d;

    always_comb begin
        addr_d  = addr_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        if (load) begin
            addr_d  = base;
            beat_d  = '0;
            burst_d = '0;
        end else if (step) begin
            addr_d = addr_q + AW'(STEP);
            if (last_beat) begin
                beat_d  = '0;
                burst_d = burst_q + 16'd1;
            end else begin
                beat_d = beat_q + BLW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            beat_q  <= '0;
            burst_q <= '0;
        end else begin
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdrc_wb_traffic_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdrc_wb_traffic_gen : Wishbone burst write / read-check traffic generator |
// | Revision            : 1.0                                                 |
// +--------------------------------------------------------------------------+
module sdrc_wb_traffic_gen
    import sdrc_tg_pkg::*;
#(
    parameter int          DW   = 32,
    parameter int          AW   = 26,
    parameter int          BLW  = 5,
    parameter logic [31:0] SEED = 32'hA5A5_5A5A
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            sdr_init_done,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [AW-1:0]   base_addr,
    input  logic [BLW-1:0]  burst_len,
    input  logic [15:0]     num_bursts,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_cnt,
    output logic [AW-1:0]   first_err_addr
);

    localparam int BPW = DW / 8;
    localparam int SH  = $clog2(BPW);

    tg_state_e       state_q, state_d;
    logic [1:0]      mode_q;
    logic [AW-1:0]   base_q;
    logic [BLW-1:0]  blen_q;
    logic [15:0]     nb_q;
    logic            cyc_q, we_q, busy_q, done_q;
    logic [DW/8-1:0] sel_q;
    logic [DW-1:0]   dat_q;
    logic [15:0]     err_q;
    logic [AW-1:0]   ferr_q;

    logic            w_load, w_step, w_in_burst, w_accept, w_miss, w_burst_d;
    logic            w_last_beat, w_last_burst;
    logic [AW-1:0]   w_addr, w_addr_nxt;
    logic [31:0]     w_wr_pat, w_exp_pat;

    assign w_in_burst = (state_q == ST_WR_BURST) || (state_q == ST_RD_BURST);
    assign w_step     = w_in_burst && wb_ack_i;
    assign w_accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_burst_d  = (state_d == ST_WR_BURST) || (state_d == ST_RD_BURST);
    // Write data is registered, so it is derived from the next address.
    assign w_wr_pat   = tg_pattern(32'(w_addr_nxt >> SH), SEED);
    assign w_exp_pat  = tg_pattern(32'(w_addr >> SH), SEED);
    assign w_miss     = (state_q == ST_RD_BURST) && wb_ack_i
                        && (wb_dat_i != w_exp_pat[DW-1:0]);

    sdrc_tg_agen #(
        .AW   (AW),
        .BLW  (BLW),
        .STEP (BPW)
    ) u_agen (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .load         (w_load),
        .step         (w_step),
        .base         (base_q),
        .burst_len_i  (blen_q),
        .num_bursts_i (nb_q),
        .addr         (w_addr),
        .addr_nxt_o   (w_addr_nxt),
        .last_beat    (w_last_beat),
        .last_burst   (w_last_burst)
    );

    always_comb begin
        state_d = state_q;
        w_load  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (sdr_init_done) begin
                    if (nb_q == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        w_load  = 1'b1;
                        state_d = (mode_q == TG_RD) ? ST_RD_BURST : ST_WR_BURST;
                    end
                end
            end
            ST_WR_BURST: begin
                if (wb_ack_i && w_last_beat) state_d = ST_WR_GAP;
            end
            ST_WR_GAP: begin
                if (!w_last_burst) begin
                    state_d = ST_WR_BURST;
                end else if (mode_q == TG_WR) begin
                    state_d = ST_DONE;
                end else begin
                    w_load  = 1'b1;
                    state_d = ST_RD_BURST;
                end
            end
            ST_RD_BURST: begin
                if (wb_ack_i && w_last_beat) state_d = ST_RD_GAP;
            end
            ST_RD_GAP: begin
                state_d = w_last_burst ? ST_DONE : ST_RD_BURST;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            base_q  <= '0;
            blen_q  <= '0;
            nb_q    <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= w_burst_d;
            we_q    <= (state_d == ST_WR_BURST);
            sel_q   <= w_burst_d ? '1 : '0;
            dat_q   <= (state_d == ST_WR_BURST) ? w_wr_pat[DW-1:0] : '0;
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q  <= (state_d == ST_DONE);
            if (w_accept) begin
                mode_q <= mode;
                base_q <= base_addr;
                blen_q <= burst_len;
                nb_q   <= num_bursts;
                err_q  <= '0;
                ferr_q <= '0;
            end else if (w_miss) begin
                if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                if (err_q == 16'd0) ferr_q <= w_addr;
            end
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;
    assign wb_we_o        = we_q;
    assign wb_adr_o       = w_addr;
    assign wb_sel_o       = sel_q;
    assign wb_dat_o       = dat_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;

endmodule
`default_nettype wire
